ahb3lite_sram_slave: RTL and testbench
======================================

Name: ahb3lite_sram_slave

Overview:
AHB-Lite responder (slave) holding a word-organised SRAM. It sits on the slave side of the bus and is paired with the master-side checker to close the loop in formal and simulation. It accepts single and burst transfers and inserts a configurable number of wait states. Illegal accesses get the two-cycle ERROR response.

Parameters:
MEM_WORDS, 1024, number of 32-bit words; byte capacity is 4*MEM_WORDS; must be a power of two, 1..16384
WAIT_STATES, 0, wait cycles inserted into each OKAY data phase; range 0..15

Ports:
HCLK  input  1  bus clock; all logic on the rising edge
HRESET  input  1  synchronous, active-high reset
HSEL  input  1  slave select
HADDR  input  16  byte address
HTRANS  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
HWRITE  input  1  1=write, 0=read
HSIZE  input  3  0=byte, 1=halfword, 2=word
HBURST  input  3  burst type; ignored, because every beat carries its own address
HPROT  input  4  protection; ignored
HWDATA  input  32  write data, sampled in the data phase
HREADY  input  1  bus-level ready (muxed HREADYOUT)
HRDATA  output  32  read data
HREADYOUT  output  1  slave ready
HRESP  output  1  0=OKAY, 1=ERROR

Behaviour:
- Reset (HRESET=1 at an edge):
  - state goes to IDLE; HREADYOUT=1, HRESP=0, HRDATA=0; wait counter=0.
  - Memory contents are not cleared.
  - Reset mid data phase abandons the transfer; a pending write is not committed.
- Address-phase acceptance: at an edge where HSEL & HREADY & HTRANS[1].
  - Latch HADDR, HWRITE and HSIZE.
  - IDLE/BUSY, or HSEL=0: no transfer; the next cycle is zero-wait OKAY.
- Error decode at acceptance; any of these gives ERROR:
  - HADDR >= 4*MEM_WORDS
  - HSIZE > 2
  - HSIZE=1 with HADDR[0]=1
  - HSIZE=2 with HADDR[1:0]!=0
- States:
  - IDLE: HREADYOUT=1, HRESP=0.
    - Accepted error -> ERR1.
    - Accepted valid transfer with WAIT_STATES>0 -> WAIT, counter=WAIT_STATES.
    - Accepted valid transfer with WAIT_STATES=0 -> DATA.
  - WAIT: HREADYOUT=0, HRESP=0. The counter decrements each cycle; at 1 -> DATA.
  - DATA: HREADYOUT=1, HRESP=0; this is the final data-phase cycle.
    - A write commits HWDATA at the closing edge.
    - A new acceptance at the same edge follows the same rules as from IDLE; otherwise -> IDLE.
  - ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1.
    - Acceptance at this edge is allowed (same rules as IDLE); otherwise -> IDLE.
    - No memory change and no HRDATA update for an errored transfer.
- Write byte lanes (little-endian), word index HADDR[15:2]:
  - byte: lane HADDR[1:0]
  - halfword: lanes {HADDR[1],0} and {HADDR[1],1}
  - word: all four lanes
  - Other lanes are preserved.
- Read:
  - The word is fetched at acceptance into HRDATA. It is presented unmodified (full 32 bits) and is valid when HREADYOUT=1 in DATA.
  - HRDATA holds its value in every other cycle.
- Read-after-write forwarding: a read accepted at the same edge a write commits to the same word returns the merged data. The written lanes come from HWDATA, the rest from memory. The response never returns stale data.
- Master aborting after ERR1 by driving IDLE in ERR2 is legal and needs no special handling.
- Latency:
  - OKAY transfer: 1+WAIT_STATES data-phase cycles.
  - ERROR: exactly 2 cycles, regardless of WAIT_STATES.

Test Plan:
- WAIT_STATES=0: write word 0xDEADBEEF @0x0010, then read @0x0010 back-to-back -> read data phase HRDATA=0xDEADBEEF (forwarded), HREADYOUT=1, HRESP=0 in both data phases.
- Byte write 0xAA to @0x0013 over word 0x11223344, then word read @0x0010 -> HRDATA=0xAA223344.
- WAIT_STATES=3: NONSEQ read @0x0004 -> HREADYOUT low for exactly 3 cycles, then high with correct data; HRESP=0 throughout.
- Word access @0x0002, and any access @0x1000 with MEM_WORDS=1024:
  - Each gives HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1.
  - Memory is unchanged and HRDATA is unchanged.
- INCR4 write burst @0x0020 (NONSEQ then 3×SEQ, one BUSY inserted) -> four words written; BUSY gives a zero-wait OKAY; readback matches.
- HRESET asserted during WAIT of a write -> next cycle HREADYOUT=1, HRESP=0, HRDATA=0; the target word keeps its old value.

Source files
------------

// File: rtl/ahb3lite_sram_slave.sv
// AHB-Lite responder backed by a word-organised SRAM.
// Configurable wait states, two-cycle ERROR, read-after-write forwarding.
module ahb3lite_sram_slave #(
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [15:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int          IW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [16:0] BYTES = 17'(4 * MEM_WORDS);
    localparam logic [3:0]  WS    = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_cnt;
    logic [3:0]    w_cnt_next;
    logic [IW-1:0] r_idx;
    logic [1:0]    r_lo;
    logic [1:0]    r_size;
    logic          r_write;
    logic [31:0]   r_rdata;
    logic [31:0]   r_mem [MEM_WORDS];

    logic          w_accept;
    logic          w_err;
    logic          w_commit;
    logic          w_fwd;
    logic [IW-1:0] w_aidx;
    logic [3:0]    w_be;
    logic [31:0]   w_rword;
    logic [31:0]   w_rmerge;
    logic          w_unused;

    assign w_unused = &{1'b0, HTRANS[0], HBURST, HPROT};

    assign w_accept = HSEL & HREADY & HTRANS[1] & HREADYOUT;
    assign w_err    = ({1'b0, HADDR} >= BYTES)
                    | (HSIZE > 3'd2)
                    | ((HSIZE == 3'd1) & HADDR[0])
                    | ((HSIZE == 3'd2) & (|HADDR[1:0]));
    assign w_aidx   = HADDR[IW+1:2];
    assign w_commit = (r_state == S_DATA) & r_write & ~HRESET;
    assign w_fwd    = w_commit & (r_idx == w_aidx);
    assign w_rword  = r_mem[w_aidx];

    always_comb begin
        w_be = 4'b1111;
        case (r_size)
            2'd0:    w_be = 4'b0001 << r_lo;
            2'd1:    w_be = r_lo[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    // A read landing on the word being committed this edge sees the new lanes
    always_comb begin
        w_rmerge = w_rword;
        for (int i = 0; i < 4; i++) begin
            if (w_fwd & w_be[i]) begin
                w_rmerge[8*i +: 8] = HWDATA[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            S_WAIT: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_next = S_DATA;
                end
            end
            S_ERR1: w_next = S_ERR2;
            default: begin
                w_next = S_IDLE;
                if (w_accept) begin
                    if (w_err) begin
                        w_next = S_ERR1;
                    end else if (WS != 4'd0) begin
                        w_next     = S_WAIT;
                        w_cnt_next = WS;
                    end else begin
                        w_next = S_DATA;
                    end
                end
            end
        endcase
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        if (r_state == S_WAIT || r_state == S_ERR1) begin
            HREADYOUT = 1'b0;
        end
        if (r_state == S_ERR1 || r_state == S_ERR2) begin
            HRESP = 1'b1;
        end
    end

    assign HRDATA = r_rdata;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_accept & ~w_err & ~HWRITE) begin
                r_rdata <= w_rmerge;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (w_accept) begin
            r_idx   <= w_aidx;
            r_lo    <= HADDR[1:0];
            r_size  <= HSIZE[1:0];
            r_write <= HWRITE;
        end
    end

    always_ff @(posedge HCLK) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[r_idx][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Bench for ahb3lite_sram_slave: a zero-wait and a three-wait instance
// driven from a pipelined vector table with an expected-result queue.
module tb_ahb3lite_sram_slave;

    typedef struct {
        int          id;
        bit          sel;
        logic [1:0]  tr;
        logic        wr;
        logic [2:0]  sz;
        logic [15:0] ad;
        logic [31:0] wd;
        logic        rsp;
        logic [31:0] rd;
    } vec_t;

    localparam logic [1:0] ID = 2'b00;
    localparam logic [1:0] BZ = 2'b01;
    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] SQ = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel;
    bit          sel;
    logic [15:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hsel0, hsel1;
    logic [31:0] rd0, rd1, o_rd;
    logic        ro0, ro1, o_ro;
    logic        rs0, rs1, o_rs;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vt[40];
    int   nv = 0;
    vec_t sbq[$];

    always #5 clk = ~clk;

    assign hsel0 = hsel & ~sel;
    assign hsel1 = hsel & sel;
    assign o_rd  = sel ? rd1 : rd0;
    assign o_ro  = sel ? ro1 : ro0;
    assign o_rs  = sel ? rs1 : rs0;

    ahb3lite_sram_slave #(.MEM_WORDS(1024), .WAIT_STATES(0)) u_ws0 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel0), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize),
        .HBURST(3'b001), .HPROT(4'b0011), .HWDATA(hwdata),
        .HREADY(ro0), .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(rs0)
    );

    ahb3lite_sram_slave #(.MEM_WORDS(1024), .WAIT_STATES(3)) u_ws3 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel1), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize),
        .HBURST(3'b001), .HPROT(4'b0011), .HWDATA(hwdata),
        .HREADY(ro1), .HRDATA(rd1), .HREADYOUT(ro1), .HRESP(rs1)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic add(input bit s, input logic [1:0] t, input logic w,
                       input logic [2:0] z, input logic [15:0] a,
                       input logic [31:0] d, input logic r,
                       input logic [31:0] e);
        vt[nv].id  = nv;
        vt[nv].sel = s;
        vt[nv].tr  = t;
        vt[nv].wr  = w;
        vt[nv].sz  = z;
        vt[nv].ad  = a;
        vt[nv].wd  = d;
        vt[nv].rsp = r;
        vt[nv].rd  = e;
        nv++;
    endtask

    function automatic int expw(input vec_t x);
        if (!x.tr[1]) return 0;
        if (x.rsp) return 1;
        return x.sel ? 3 : 0;
    endfunction

    task automatic drive_ap(input vec_t x);
        hsel   = 1'b1;
        htrans = x.tr;
        haddr  = x.ad;
        hwrite = x.wr;
        hsize  = x.sz;
    endtask

    task automatic drive_idle();
        hsel   = 1'b0;
        htrans = ID;
    endtask

    // Called just after a rising edge with the selected slave idle.
    task automatic run(input int lo, input int hi);
        int   i;
        bit   apv, dpv;
        int   waits, cyc;
        logic rdy;
        vec_t d;
        i = lo; apv = 0; dpv = 0; waits = 0; cyc = 0;
        sel = vt[lo].sel;
        if (i <= hi) begin
            drive_ap(vt[i]); sbq.push_back(vt[i]); apv = 1; i++;
        end
        while ((apv || dpv) && cyc < 300) begin
            @(negedge clk);
            cyc++;
            rdy = o_ro;
            if (dpv) begin
                chk($sformatf("v%0d hresp", d.id), 32'(o_rs), 32'(d.rsp));
                if (rdy) begin
                    chk($sformatf("v%0d waits", d.id), 32'(waits), 32'(expw(d)));
                    chk($sformatf("v%0d hrdata", d.id), o_rd, d.rd);
                    dpv = 0;
                end else begin
                    waits++;
                end
            end
            @(posedge clk);
            #1;
            if (rdy) begin
                if (apv) begin
                    d = sbq.pop_front();
                    dpv = 1; waits = 0; apv = 0;
                    hwdata = d.wd;
                end
                if (i <= hi) begin
                    drive_ap(vt[i]); sbq.push_back(vt[i]); apv = 1; i++;
                end else begin
                    drive_idle();
                end
            end
        end
        if (apv || dpv) begin
            n_tests++;
            n_fail++;
            $display("FAIL run v%0d-v%0d: timeout, no HREADYOUT", lo, hi);
            sbq.delete();
            drive_idle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        add(0, NS, 1, 2, 16'h0000, 32'h01020304, 0, 32'h00000000);
        add(0, NS, 1, 2, 16'h0010, 32'hDEADBEEF, 0, 32'h00000000);
        add(0, NS, 0, 2, 16'h0010, 32'h0,        0, 32'hDEADBEEF);
        add(0, NS, 1, 2, 16'h0010, 32'h11223344, 0, 32'hDEADBEEF);
        add(0, NS, 1, 0, 16'h0013, 32'hAA000000, 0, 32'hDEADBEEF);
        add(0, NS, 0, 2, 16'h0010, 32'h0,        0, 32'hAA223344);
        add(0, NS, 1, 2, 16'h0012, 32'h55555555, 1, 32'hAA223344);
        add(0, NS, 1, 2, 16'h1000, 32'h66666666, 1, 32'hAA223344);
        add(0, NS, 0, 2, 16'h0010, 32'h0,        0, 32'hAA223344);
        add(0, NS, 0, 0, 16'h0011, 32'h0,        0, 32'hAA223344);
        add(0, NS, 0, 2, 16'h0000, 32'h0,        0, 32'h01020304);
        add(0, NS, 1, 2, 16'h0014, 32'h0BADF00D, 0, 32'h01020304);
        add(0, NS, 1, 1, 16'h0016, 32'h12340000, 0, 32'h01020304);
        add(0, NS, 0, 1, 16'h0015, 32'h0,        1, 32'h01020304);
        add(0, NS, 0, 3, 16'h0014, 32'h0,        1, 32'h01020304);
        add(0, NS, 0, 2, 16'h0014, 32'h0,        0, 32'h1234F00D);
        add(0, ID, 0, 2, 16'h0000, 32'h0,        0, 32'h1234F00D);
        add(0, NS, 1, 2, 16'h0020, 32'hA0A0A0A0, 0, 32'h1234F00D);
        add(0, SQ, 1, 2, 16'h0024, 32'hA1A1A1A1, 0, 32'h1234F00D);
        add(0, BZ, 1, 2, 16'h0028, 32'h0,        0, 32'h1234F00D);
        add(0, SQ, 1, 2, 16'h0028, 32'hA2A2A2A2, 0, 32'h1234F00D);
        add(0, SQ, 1, 2, 16'h002C, 32'hA3A3A3A3, 0, 32'h1234F00D);
        add(0, NS, 0, 2, 16'h0020, 32'h0,        0, 32'hA0A0A0A0);
        add(0, SQ, 0, 2, 16'h0024, 32'h0,        0, 32'hA1A1A1A1);
        add(0, SQ, 0, 2, 16'h0028, 32'h0,        0, 32'hA2A2A2A2);
        add(0, SQ, 0, 2, 16'h002C, 32'h0,        0, 32'hA3A3A3A3);
        add(1, NS, 1, 2, 16'h0004, 32'hCAFEF00D, 0, 32'h00000000);
        add(1, NS, 0, 2, 16'h0004, 32'h0,        0, 32'hCAFEF00D);
        add(1, NS, 0, 2, 16'h0002, 32'h0,        1, 32'hCAFEF00D);
        add(1, NS, 0, 0, 16'h1000, 32'h0,        1, 32'hCAFEF00D);
        add(1, NS, 0, 2, 16'h0004, 32'h0,        0, 32'hCAFEF00D);
        add(1, NS, 0, 2, 16'h0004, 32'h0,        0, 32'hCAFEF00D);

        rst = 1'b1; sel = 0; hsel = 1'b0; htrans = ID;
        haddr = '0; hwrite = 1'b0; hsize = 3'd2; hwdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset ws0 hreadyout", 32'(ro0), 32'd1);
        chk("reset ws0 hresp", 32'(rs0), 32'd0);
        chk("reset ws0 hrdata", rd0, 32'd0);
        chk("reset ws3 hreadyout", 32'(ro1), 32'd1);
        chk("reset ws3 hresp", 32'(rs1), 32'd0);
        chk("reset ws3 hrdata", rd1, 32'd0);
        @(posedge clk);
        #1;
        run(0, 25);
        run(26, 30);

        sel = 1; hsel = 1'b1; htrans = NS; hwrite = 1'b1;
        hsize = 3'd2; haddr = 16'h0004;
        @(negedge clk);
        chk("midrst accept ready", 32'(o_ro), 32'd1);
        @(posedge clk);
        #1;
        drive_idle();
        hwdata = 32'h99999999;
        @(negedge clk);
        chk("midrst wait ready", 32'(o_ro), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst hreadyout", 32'(o_ro), 32'd1);
        chk("midrst hresp", 32'(o_rs), 32'd0);
        chk("midrst hrdata", o_rd, 32'd0);
        @(posedge clk);
        #1;
        run(31, 31);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
